// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared definitions for the fetch controller: PC-source
//                select width and encodings, FSM state encoding, flush
//                counter width and a redirect-detection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int SEL_PC_WIDTH    = 2;
    localparam int FLUSH_CNT_WIDTH = 2;

    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_PLUS4  = 2'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_BRANCH = 2'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JUMP   = 2'd2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // A redirect is any taken branch or any non-sequential PC source.
    function automatic logic is_redirect(input logic                    br,
                                         input logic [SEL_PC_WIDTH-1:0] sel);
        return br || (sel != SEL_PC_PLUS4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Datapath <-> fetch controller signal bundle.
//                master = fetch controller (drives c_* / halted),
//                slave  = datapath (drives status and redirect requests).
//                Performance counter signals exist only when
//                FETCH_CTRL_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                    memory_done;
    logic [SEL_PC_WIDTH-1:0] pc_sel;
    logic                    br_taken;
    logic [31:0]             ir;
    logic [31:0]             next_pc;

    logic                    c_fetch_stall;
    logic [SEL_PC_WIDTH-1:0] c_pc_sel;
    logic                    c_br_taken;
    logic [31:0]             c_next_pc;
    logic                    halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_redirect_cnt;
`endif

    modport master (
        input  memory_done, pc_sel, br_taken, ir, next_pc,
`ifdef FETCH_CTRL_PERF_EN
        output perf_stall_cnt, perf_redirect_cnt,
`endif
        output c_fetch_stall, c_pc_sel, c_br_taken, c_next_pc, halted
    );

    modport slave (
        output memory_done, pc_sel, br_taken, ir, next_pc,
`ifdef FETCH_CTRL_PERF_EN
        input  perf_stall_cnt, perf_redirect_cnt,
`endif
        input  c_fetch_stall, c_pc_sel, c_br_taken, c_next_pc, halted
    );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch/PC-update controller. Stalls fetch while memory is
//                busy, queues one pending redirect during a stall, inserts
//                FLUSH_CYCLES flush cycles on a redirect and halts on an
//                illegal instruction. All outputs are registered.
//                Optional macro FETCH_CTRL_PERF_EN adds stall/redirect
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_IR   = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1            // legal range 1..3
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

    state_t                     state_q,     state_d;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic                       pend_vld_q,  pend_vld_d;
    logic [SEL_PC_WIDTH-1:0]    pend_sel_q,  pend_sel_d;
    logic                       pend_br_q,   pend_br_d;
    logic [31:0]                pend_pc_q,   pend_pc_d;

    logic                       stall_q,     stall_d;
    logic [SEL_PC_WIDTH-1:0]    sel_q,       sel_d;
    logic                       br_q,        br_d;
    logic [31:0]                npc_q,       npc_d;
    logic                       halted_q,    halted_d;

    logic                       w_redirect;
    logic                       w_illegal;
    logic                       w_take_vld;
    logic [SEL_PC_WIDTH-1:0]    w_take_sel;
    logic                       w_take_br;
    logic [31:0]                w_take_pc;

    assign w_redirect = is_redirect(bus.br_taken, bus.pc_sel);
    assign w_illegal  = (bus.ir == ILLEGAL_IR);

    // Redirect to apply when a stall ends: the held one wins, otherwise a
    // redirect arriving in the very cycle memory completes is used directly.
    assign w_take_vld = pend_vld_q || w_redirect;
    assign w_take_sel = pend_vld_q ? pend_sel_q : bus.pc_sel;
    assign w_take_br  = pend_vld_q ? pend_br_q  : bus.br_taken;
    assign w_take_pc  = pend_vld_q ? pend_pc_q  : bus.next_pc;

    // State, pending redirect, flush counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_sel_q  <= SEL_PC_PLUS4;
            pend_br_q   <= 1'b0;
            pend_pc_q   <= 32'h0;
            stall_q     <= 1'b1;
            sel_q       <= SEL_PC_PLUS4;
            br_q        <= 1'b0;
            npc_q       <= 32'h0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_sel_q  <= pend_sel_d;
            pend_br_q   <= pend_br_d;
            pend_pc_q   <= pend_pc_d;
            stall_q     <= stall_d;
            sel_q       <= sel_d;
            br_q        <= br_d;
            npc_q       <= npc_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_sel_d  = pend_sel_q;
        pend_br_d   = pend_br_q;
        pend_pc_d   = pend_pc_q;
        stall_d     = stall_q;
        sel_d       = sel_q;
        br_d        = br_q;
        npc_d       = npc_q;
        halted_d    = halted_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                stall_d = 1'b0;
                sel_d   = SEL_PC_PLUS4;
                br_d    = 1'b0;
            end

            ST_RUN: begin
                if (w_illegal) begin
                    state_d  = ST_HALT;
                    stall_d  = 1'b1;
                    halted_d = 1'b1;
                    sel_d    = SEL_PC_PLUS4;
                    br_d     = 1'b0;
                    npc_d    = 32'h0;
                end else if (!bus.memory_done) begin
                    state_d = ST_STALL;
                    stall_d = 1'b1;
                    if (w_redirect) begin
                        pend_vld_d = 1'b1;
                        pend_sel_d = bus.pc_sel;
                        pend_br_d  = bus.br_taken;
                        pend_pc_d  = bus.next_pc;
                    end
                end else if (w_redirect) begin
                    state_d     = ST_FLUSH;
                    stall_d     = 1'b1;
                    sel_d       = bus.pc_sel;
                    br_d        = bus.br_taken;
                    npc_d       = bus.next_pc;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end

            ST_STALL: begin
                // First redirect seen during the stall is held; later ones drop.
                if (!pend_vld_q && w_redirect) begin
                    pend_vld_d = 1'b1;
                    pend_sel_d = bus.pc_sel;
                    pend_br_d  = bus.br_taken;
                    pend_pc_d  = bus.next_pc;
                end
                if (bus.memory_done) begin
                    pend_vld_d = 1'b0;
                    if (w_take_vld) begin
                        state_d     = ST_FLUSH;
                        sel_d       = w_take_sel;
                        br_d        = w_take_br;
                        npc_d       = w_take_pc;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        stall_d = 1'b0;
                    end
                end
            end

            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                    stall_d = 1'b0;
                    sel_d   = SEL_PC_PLUS4;
                    br_d    = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
                stall_d = 1'b1;
            end
        endcase
    end

    assign bus.c_fetch_stall = stall_q;
    assign bus.c_pc_sel      = sel_q;
    assign bus.c_br_taken    = br_q;
    assign bus.c_next_pc     = npc_q;
    assign bus.halted        = halted_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_redirect_q;

    // Count stalled STALL/FLUSH cycles and every entry into FLUSH; both wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q    <= 32'h0;
            perf_redirect_q <= 32'h0;
        end else begin
            if (stall_q && (state_q == ST_STALL || state_q == ST_FLUSH)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (state_d == ST_FLUSH && state_q != ST_FLUSH) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt    = perf_stall_q;
    assign bus.perf_redirect_cnt = perf_redirect_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. A driver issues
//                directed then random stimulus and pushes the expected
//                registered outputs into a queue; a monitor pops and
//                compares one entry per clock. Perf counters are checked
//                when FETCH_CTRL_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] ILLEGAL = 32'h0000_0000;
    localparam int          FC      = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic                    stall;
        logic [SEL_PC_WIDTH-1:0] sel;
        logic                    br;
        logic [31:0]             npc;
        logic                    halted;
        logic [31:0]             pstall;
        logic [31:0]             predir;
    } exp_t;

    typedef struct packed {
        logic [SEL_PC_WIDTH-1:0] sel;
        logic                    br;
        logic [31:0]             pc;
    } redir_t;

    localparam exp_t RESET_EXP = '{stall: 1'b1, sel: SEL_PC_PLUS4, br: 1'b0,
                                   npc: 32'h0, halted: 1'b0, pstall: 32'h0, predir: 32'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_ctrl_if bus ();

    fetch_ctrl #(.ILLEGAL_IR(ILLEGAL), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, want);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    bit       m_idle, m_halt, m_wait;
    int       m_flush_left;
    redir_t   m_pend[$];
    exp_t     m_out;
    int       m_halt_cycles;

    task automatic start_flush(input redir_t r);
        m_flush_left = FC;
        m_out.stall  = 1'b1;
        m_out.sel    = r.sel;
        m_out.br     = r.br;
        m_out.npc    = r.pc;
        m_out.predir = m_out.predir + 32'd1;
    endtask

    task automatic model_step(input bit r, input bit md, input logic [SEL_PC_WIDTH-1:0] sel,
                              input bit br, input logic [31:0] ir, input logic [31:0] npc);
        bit     redir;
        redir_t nr;
        redir = br || (sel != 0);
        nr    = '{sel: sel, br: br, pc: npc};
        if (r) begin
            m_idle = 1; m_halt = 0; m_wait = 0; m_flush_left = 0;
            m_pend.delete();
            m_out  = RESET_EXP;
            return;
        end
        if (m_wait || m_flush_left > 0) m_out.pstall = m_out.pstall + 32'd1;
        if (m_halt) begin
            // nothing changes until reset
        end else if (m_idle) begin
            m_idle      = 0;
            m_out.stall = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_out.stall = 1'b0;
                m_out.sel   = 0;
                m_out.br    = 1'b0;
            end
        end else if (m_wait) begin
            if (m_pend.size() == 0 && redir) m_pend.push_back(nr);
            if (md) begin
                m_wait = 0;
                if (m_pend.size() != 0) start_flush(m_pend.pop_front());
                else m_out.stall = 1'b0;
            end
        end else begin
            if (ir == ILLEGAL) begin
                m_halt       = 1;
                m_out.stall  = 1'b1;
                m_out.halted = 1'b1;
                m_out.sel    = 0;
                m_out.br     = 1'b0;
                m_out.npc    = 32'h0;
            end else if (!md) begin
                m_wait      = 1;
                m_out.stall = 1'b1;
                if (redir) m_pend.push_back(nr);
            end else if (redir) begin
                start_flush(nr);
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, queue the expectation.
    task automatic cycle(input bit r, input bit md, input logic [SEL_PC_WIDTH-1:0] sel,
                         input bit br, input logic [31:0] ir, input logic [31:0] npc);
        bit rst_rise;
        @(negedge clk);
        rst_rise        = r && !rst;
        rst             = r;
        bus.memory_done = md;
        bus.pc_sel      = sel;
        bus.br_taken    = br;
        bus.ir          = ir;
        bus.next_pc     = npc;
        model_step(r, md, sel, br, ir, npc);
        exp_q.push_back(m_out);
        if (rst_rise) begin
            #1;
            chk("async_rst_stall",  {31'h0, bus.c_fetch_stall}, 32'h1);
            chk("async_rst_sel",    {30'h0, bus.c_pc_sel},      32'h0);
            chk("async_rst_br",     {31'h0, bus.c_br_taken},    32'h0);
            chk("async_rst_npc",    bus.c_next_pc,              32'h0);
            chk("async_rst_halted", {31'h0, bus.halted},        32'h0);
        end
        m_halt_cycles = m_halt ? m_halt_cycles + 1 : 0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, NOP, 32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("c_fetch_stall", {31'h0, bus.c_fetch_stall}, {31'h0, e.stall});
                chk("c_pc_sel",      {30'h0, bus.c_pc_sel},      {30'h0, e.sel});
                chk("c_br_taken",    {31'h0, bus.c_br_taken},    {31'h0, e.br});
                chk("c_next_pc",     bus.c_next_pc,              e.npc);
                chk("halted",        {31'h0, bus.halted},        {31'h0, e.halted});
`ifdef FETCH_CTRL_PERF_EN
                chk("perf_stall_cnt",    bus.perf_stall_cnt,    e.pstall);
                chk("perf_redirect_cnt", bus.perf_redirect_cnt, e.predir);
`endif
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        bit                      r, md, br;
        logic [SEL_PC_WIDTH-1:0] sel;
        logic [31:0]             ir, npc;

        bus.memory_done = 1'b0;
        bus.pc_sel      = SEL_PC_PLUS4;
        bus.br_taken    = 1'b0;
        bus.ir          = NOP;
        bus.next_pc     = 32'h0;
        m_out           = RESET_EXP;
        m_halt_cycles   = 0;

        // Reset with all inputs low, then release into RUN.
        cycle(1, 0, 0, 0, NOP, 32'h0);
        cycle(1, 0, 0, 0, NOP, 32'h0);
        run_idle(3);

        // Memory busy for three cycles, no redirect.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, NOP, 32'h0);
        run_idle(3);

        // Taken branch to 0x100 with memory complete.
        cycle(0, 1, SEL_PC_BRANCH, 1, NOP, 32'h0000_0100);
        run_idle(FC + 2);

        // Redirect to 0x200 during a stall; a later 0x300 must be ignored.
        cycle(0, 0, SEL_PC_BRANCH, 1, NOP, 32'h0000_0200);
        cycle(0, 0, SEL_PC_JUMP,   0, NOP, 32'h0000_0300);
        cycle(0, 1, 0, 0, NOP, 32'h0);
        run_idle(FC + 2);

        // Illegal instruction halts; inputs afterwards have no effect.
        cycle(0, 1, 0, 0, ILLEGAL, 32'h0);
        cycle(0, 1, SEL_PC_JALR, 1, NOP, 32'h0000_0444);
        cycle(0, 0, 0, 0, NOP, 32'h0);
        cycle(0, 1, 0, 0, NOP, 32'h0);

        // Reset out of HALT, then reset again in the middle of a FLUSH.
        cycle(1, 0, 0, 0, NOP, 32'h0);
        run_idle(2);
        cycle(0, 1, SEL_PC_JUMP, 0, NOP, 32'h0000_0500);
        cycle(1, 1, 0, 0, NOP, 32'h0);
        run_idle(3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 149) == 0) || (m_halt_cycles > 4);
            md  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 4) == 0);
            sel = ($urandom_range(0, 3) == 0) ? SEL_PC_WIDTH'($urandom_range(0, 3)) : SEL_PC_PLUS4;
            ir  = ($urandom_range(0, 59) == 0) ? ILLEGAL : ($urandom() | 32'h1);
            npc = $urandom() & 32'hFFFF_FFFC;
            cycle(r, md, sel, br, ir, npc);
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: ILLEGAL_IR, default 32'h0000_0000, instruction word treated as illegal and causing halt.
REQ-002 Parameter: FLUSH_CYCLES, default 1, range 1..3, number of stall cycles inserted on a redirect.
REQ-003 clk  in  1  single core clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 memory_done  in  1  datapath memory access for current instruction complete.
REQ-006 pc_sel  in  `SEL_PC_WIDTH  PC source requested by datapath decode.
REQ-007 br_taken  in  1  datapath branch-condition result.
REQ-008 ir  in  32  instruction currently in datapath.
REQ-009 next_pc  in  32  datapath-computed redirect target.
REQ-010 c_fetch_stall  out  1  freeze fetch/PC update.
REQ-011 c_pc_sel  out  `SEL_PC_WIDTH  PC source applied by datapath.
REQ-012 c_br_taken  out  1  branch taken applied by datapath.
REQ-013 c_next_pc  out  32  redirect target applied by datapath.
REQ-014 halted  out  1  controller in HALT.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 FSM states SHALL be IDLE, RUN, STALL, FLUSH, HALT.
REQ-017 IDLE: stall=1; next state RUN unconditionally (exactly one IDLE cycle after reset release).
REQ-018 RUN: stall=0, c_pc_sel=SEL_PC_PLUS4, c_br_taken=0.
REQ-019 RUN, ir==ILLEGAL_IR: -> HALT, overriding all other events.
REQ-020 RUN, memory_done=0: -> STALL; if redirect (br_taken=1 or pc_sel!=SEL_PC_PLUS4) also present, capture pc_sel/br_taken/next_pc into pending register.
REQ-021 RUN, memory_done=1 with redirect: -> FLUSH, c_pc_sel/c_br_taken/c_next_pc loaded from inputs on same edge.
REQ-022 STALL: stall=1; redirects arriving while pending empty SHALL be captured; first capture wins, later ones ignored.
REQ-023 STALL, memory_done=1: -> FLUSH with pending values driven if pending valid (pending cleared), else -> RUN.
REQ-024 FLUSH: stall=1, redirect outputs held constant for FLUSH_CYCLES cycles (down-counter), then -> RUN with c_pc_sel=SEL_PC_PLUS4, c_br_taken=0; c_next_pc retains last target.
REQ-025 Inputs other than ir SHALL be ignored in FLUSH; ILLEGAL_IR in STALL/FLUSH ignored.
REQ-026 HALT: stall=1, halted=1, redirect outputs at reset values; exit only by reset.

Reset
REQ-027 Asserting rst in any state, including mid-FLUSH or mid-STALL, SHALL immediately force IDLE, clear pending and flush counter.
REQ-028 Reset values: c_fetch_stall=1, c_pc_sel=SEL_PC_PLUS4, c_br_taken=0, c_next_pc=0, halted=0.

Configuration
REQ-029 Macro FETCH_CTRL_PERF_EN: when defined, adds outputs perf_stall_cnt (32, counts cycles with c_fetch_stall=1 outside IDLE/HALT) and perf_redirect_cnt (32, counts FLUSH entries); both reset to 0, wrap 0xFFFF_FFFF->0.
REQ-030 Without FETCH_CTRL_PERF_EN: ports and counters absent; remaining behaviour identical.

Structure
REQ-031 SEL_PC_WIDTH and SEL_PC_* encodings (SEL_PC_PLUS4=0) and FSM state encodings SHALL live in the shared defines package, not locally.
REQ-032 Single module; no sub-module; pending register and flush counter inline.

Verification
REQ-033 rst pulse, all inputs 0, ir=0x00000013 -> stall=1 one cycle after release, then stall=0 in RUN; all reset values checked.
REQ-034 RUN, memory_done=0 for 3 cycles -> stall=1 exactly 3 cycles, RUN resumes, no redirect.
REQ-035 RUN, br_taken=1, next_pc=0x0000_0100, memory_done=1 -> c_br_taken=1, c_next_pc=0x100, stall=1 for FLUSH_CYCLES, then c_br_taken=0.
REQ-036 memory_done=0 with redirect to 0x200, then second redirect to 0x300 during STALL -> after memory_done=1, FLUSH drives 0x200.
REQ-037 ir=0x00000000 in RUN -> halted=1, stall=1 persistent until rst; rst asserted mid-FLUSH -> IDLE same edge.
REQ-038 With FETCH_CTRL_PERF_EN: 2 stalls of 3 cycles plus one redirect (FLUSH_CYCLES=1) -> perf_stall_cnt=7, perf_redirect_cnt=1.
